// File: rtl/vec_mem_sequencer.sv
// vec_mem_sequencer
//   Converts one strided vector memory command (byte base, signed byte stride,
//   word count) into a series of 32-bit word requests on the vector port of
//   the data memory arbiter. The block counts granted-but-unanswered requests
//   and buffers load data in a small first-word-fall-through FIFO. It emits
//   one done pulse per command, together with a sticky error flag.
// Ports
//   clk_i, rst_i           : clock and synchronous active-high reset
//   cmd_*                  : command handshake (valid/ready, we, base, stride, len)
//   wdata_valid_i/wdata_i  : store data in; wdata_ready_o pulses on a store grant
//   rdata_*                : load data out (valid/ready, data, last-word flag)
//   done_o/done_err_o      : one-cycle completion pulse and its error status
//   vdata_*                : request/grant/response port toward the arbiter
module vec_mem_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OUTST  = 4,
  parameter int LEN_W      = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [31:0]      cmd_base_i,
  input  logic [31:0]      cmd_stride_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic             wdata_valid_i,
  input  logic [31:0]      wdata_i,
  output logic             wdata_ready_o,
  output logic             rdata_valid_o,
  output logic [31:0]      rdata_o,
  output logic             rdata_last_o,
  input  logic             rdata_ready_i,
  output logic             done_o,
  output logic             done_err_o,
  output logic             vdata_req_o,
  output logic             vdata_we_o,
  output logic [3:0]       vdata_be_o,
  output logic [31:0]      vdata_addr_o,
  output logic [31:0]      vdata_wdata_o,
  input  logic             vdata_gnt_i,
  input  logic             vdata_rvalid_i,
  input  logic             vdata_err_i,
  input  logic [31:0]      vdata_rdata_i
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int SW = ((CW > OW) ? CW : OW) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      stride_q, stride_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] issued_q, issued_d;
  logic [LEN_W-1:0] popped_q, popped_d;
  logic [OW-1:0]    outst_q, outst_d;
  logic             err_q, err_d;

  logic [31:0]      fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic accept, grant, resp, push, pop, req;

  // Load requests reserve FIFO space for their response up front: the count
  // already buffered plus every request still in flight must stay below the
  // depth, so a response can always be pushed. While waiting for a grant that
  // sum can only fall (a response moves one unit from outst to count, a pop
  // removes one), so req never drops before its grant.
  always_comb begin
    req = 1'b0;
    if (state_q == S_ISSUE && outst_q < OW'(MAX_OUTST)) begin
      req = we_q ? wdata_valid_i
                 : ((SW'(count_q) + SW'(outst_q)) < SW'(FIFO_DEPTH));
    end
  end

  // cmd_ready_o is masked during reset so every output reads zero then.
  assign cmd_ready_o   = (state_q == S_IDLE) && !rst_i;
  assign accept        = cmd_valid_i && cmd_ready_o;
  assign grant         = req && vdata_gnt_i;
  // A response with nothing outstanding is stale (e.g. after a reset).
  assign resp          = vdata_rvalid_i && (outst_q != '0);
  assign push          = resp && !we_q;
  assign pop           = rdata_valid_o && rdata_ready_i;

  assign rdata_valid_o = (count_q != '0);
  assign rdata_o       = rdata_valid_o ? fifo_mem[rd_ptr_q] : 32'h0;
  assign rdata_last_o  = rdata_valid_o && (popped_q == len_q - LEN_W'(1));
  assign done_o        = (state_q == S_DONE);
  assign done_err_o    = done_o && err_q;
  assign wdata_ready_o = grant && we_q;
  assign vdata_req_o   = req;
  assign vdata_we_o    = req && we_q;
  assign vdata_be_o    = 4'hF;
  assign vdata_addr_o  = addr_q;
  assign vdata_wdata_o = wdata_i;

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    len_d    = len_q;
    issued_d = issued_q;
    popped_d = popped_q;
    outst_d  = outst_q;
    err_d    = err_q;

    if (grant) begin
      addr_d   = addr_q + stride_q;
      issued_d = issued_q + LEN_W'(1);
    end
    if (grant && !resp)      outst_d = outst_q + OW'(1);
    else if (!grant && resp) outst_d = outst_q - OW'(1);
    if (resp && vdata_err_i) err_d = 1'b1;
    if (pop) popped_d = popped_q + LEN_W'(1);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d     = cmd_we_i;
          addr_d   = cmd_base_i;
          stride_d = cmd_stride_i;
          len_d    = cmd_len_i;
          issued_d = '0;
          popped_d = '0;
          outst_d  = '0;
          err_d    = 1'b0;
          if (cmd_len_i == '0) begin
            state_d = S_DONE;
          end else if (cmd_base_i[1:0] != 2'b00 || cmd_stride_i[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (grant && issued_q == len_q - LEN_W'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Looking at the next-cycle counts lets done follow the final
        // response (store) or final pop (load) by exactly one cycle.
        if (outst_d == '0 && (we_q || popped_d == len_q)) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      stride_q <= '0;
      len_q    <= '0;
      issued_q <= '0;
      popped_q <= '0;
      outst_q  <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      popped_q <= popped_d;
      outst_q  <= outst_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= vdata_rdata_i;
  end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// tb_vec_mem_sequencer
//   Directed bench for vec_mem_sequencer. A small arbiter/memory model answers
//   each granted request one cycle later with data = ~address. A monitor
//   records grants and pops, and one initial block runs the directed steps.
module tb_vec_mem_sequencer;
  localparam int LEN_W = 5;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             cmd_valid_i = 1'b0;
  logic             cmd_ready_o;
  logic             cmd_we_i = 1'b0;
  logic [31:0]      cmd_base_i = 32'h0;
  logic [31:0]      cmd_stride_i = 32'h0;
  logic [LEN_W-1:0] cmd_len_i = '0;
  logic             wdata_valid_i = 1'b0;
  logic [31:0]      wdata_i = 32'h0;
  logic             wdata_ready_o;
  logic             rdata_valid_o;
  logic [31:0]      rdata_o;
  logic             rdata_last_o;
  logic             rdata_ready_i = 1'b1;
  logic             done_o;
  logic             done_err_o;
  logic             vdata_req_o;
  logic             vdata_we_o;
  logic [3:0]       vdata_be_o;
  logic [31:0]      vdata_addr_o;
  logic [31:0]      vdata_wdata_o;
  logic             vdata_gnt_i = 1'b1;
  logic             vdata_rvalid_i;
  logic             vdata_err_i;
  logic [31:0]      vdata_rdata_i;

  always #5 clk_i = ~clk_i;

  vec_mem_sequencer #(.FIFO_DEPTH(4), .MAX_OUTST(4), .LEN_W(LEN_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_base_i(cmd_base_i), .cmd_stride_i(cmd_stride_i), .cmd_len_i(cmd_len_i),
    .wdata_valid_i(wdata_valid_i), .wdata_i(wdata_i), .wdata_ready_o(wdata_ready_o),
    .rdata_valid_o(rdata_valid_o), .rdata_o(rdata_o), .rdata_last_o(rdata_last_o),
    .rdata_ready_i(rdata_ready_i), .done_o(done_o), .done_err_o(done_err_o),
    .vdata_req_o(vdata_req_o), .vdata_we_o(vdata_we_o), .vdata_be_o(vdata_be_o),
    .vdata_addr_o(vdata_addr_o), .vdata_wdata_o(vdata_wdata_o),
    .vdata_gnt_i(vdata_gnt_i), .vdata_rvalid_i(vdata_rvalid_i),
    .vdata_err_i(vdata_err_i), .vdata_rdata_i(vdata_rdata_i)
  );

  // Memory model and monitor
  logic        resp_en = 1'b1;
  int          err_at = -1;
  logic        auto_rvalid = 1'b0;
  logic        auto_err = 1'b0;
  logic [31:0] auto_rdata = 32'h0;
  logic        man_rvalid = 1'b0;
  logic [31:0] man_rdata = 32'h0;

  assign vdata_rvalid_i = auto_rvalid | man_rvalid;
  assign vdata_rdata_i  = man_rvalid ? man_rdata : auto_rdata;
  assign vdata_err_i    = auto_rvalid & auto_err;

  logic [31:0] g_addr [64];
  logic [31:0] p_data [64];
  logic        p_last [64];
  int          g_cnt = 0;
  int          p_cnt = 0;
  int          wr_cnt = 0;
  int          req_cycles = 0;

  always @(posedge clk_i) begin
    auto_rvalid <= resp_en && vdata_req_o && vdata_gnt_i;
    auto_rdata  <= ~vdata_addr_o;
    auto_err    <= vdata_req_o && vdata_gnt_i && (g_cnt == err_at);
    if (vdata_req_o) req_cycles++;
    if (wdata_ready_o) wr_cnt++;
    if (vdata_req_o && vdata_gnt_i && g_cnt < 64) begin
      g_addr[g_cnt] = vdata_addr_o;
      g_cnt++;
    end
    if (rdata_valid_o && rdata_ready_i && p_cnt < 64) begin
      p_data[p_cnt] = rdata_o;
      p_last[p_cnt] = rdata_last_o;
      p_cnt++;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_cmd(input string tag, input logic we, input logic [31:0] base,
                          input logic [31:0] stride, input logic [LEN_W-1:0] len);
    $display("cmd %s: we=%0d base=%h stride=%h len=%0d", tag, we, base, stride, len);
    cmd_we_i = we; cmd_base_i = base; cmd_stride_i = stride; cmd_len_i = len;
    cmd_valid_i = 1'b1;
    chk({tag, "_ready"}, 32'(cmd_ready_o), 32'h1);
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    while (done_o !== 1'b1 && n < max) begin
      tick();
      n++;
    end
  endtask

  int g0, p0, w0, r0, n;

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_cmd_ready", 32'(cmd_ready_o), 32'h0);
    chk("rst_req",       32'(vdata_req_o), 32'h0);
    chk("rst_done",      32'(done_o), 32'h0);
    chk("rst_rvalid",    32'(rdata_valid_o), 32'h0);
    chk("rst_be",        32'(vdata_be_o), 32'hF);
    chk("rst_addr",      vdata_addr_o, 32'h0);
    rst_i = 1'b0;
    #1;
    chk("idle_cmd_ready", 32'(cmd_ready_o), 32'h1);

    // T1: load 0x1000 stride 4 len 3
    g0 = g_cnt; p0 = p_cnt;
    send_cmd("t1", 1'b0, 32'h1000, 32'd4, 5'd3);
    chk("t1_req_first",  32'(vdata_req_o), 32'h1);
    chk("t1_addr_first", vdata_addr_o, 32'h1000);
    wait_done(30, n);
    chk("t1_done_lat", 32'(n), 32'd5);
    chk("t1_done_err", 32'(done_err_o), 32'h0);
    chk("t1_gnts", 32'(g_cnt - g0), 32'd3);
    chk("t1_addr1", g_addr[g0+1], 32'h1004);
    chk("t1_addr2", g_addr[g0+2], 32'h1008);
    chk("t1_pops", 32'(p_cnt - p0), 32'd3);
    chk("t1_d0", p_data[p0],   32'hFFFF_EFFF);
    chk("t1_d1", p_data[p0+1], 32'hFFFF_EFFB);
    chk("t1_d2", p_data[p0+2], 32'hFFFF_EFF7);
    chk("t1_last0", 32'(p_last[p0]),   32'h0);
    chk("t1_last2", 32'(p_last[p0+2]), 32'h1);
    tick();
    chk("t1_done_1cyc", 32'(done_o), 32'h0);
    chk("t1_idle", 32'(cmd_ready_o), 32'h1);

    // T2: store 0x2000 stride -8 len 2, store data delayed 3 cycles
    g0 = g_cnt; w0 = wr_cnt;
    send_cmd("t2", 1'b1, 32'h2000, 32'hFFFF_FFF8, 5'd2);
    chk("t2_req_wait1", 32'(vdata_req_o), 32'h0);
    chk("t2_wready_wait", 32'(wdata_ready_o), 32'h0);
    tick();
    chk("t2_req_wait2", 32'(vdata_req_o), 32'h0);
    tick();
    chk("t2_req_wait3", 32'(vdata_req_o), 32'h0);
    tick();
    wdata_valid_i = 1'b1; wdata_i = 32'hDEAD_0001;
    #1;
    chk("t2_req", 32'(vdata_req_o), 32'h1);
    chk("t2_we", 32'(vdata_we_o), 32'h1);
    chk("t2_addr0", vdata_addr_o, 32'h2000);
    chk("t2_wdata0", vdata_wdata_o, 32'hDEAD_0001);
    chk("t2_wready0", 32'(wdata_ready_o), 32'h1);
    tick();
    wdata_i = 32'hDEAD_0002;
    #1;
    chk("t2_addr1", vdata_addr_o, 32'h1FF8);
    chk("t2_wready1", 32'(wdata_ready_o), 32'h1);
    tick();
    wdata_valid_i = 1'b0;
    chk("t2_req_off", 32'(vdata_req_o), 32'h0);
    wait_done(30, n);
    chk("t2_done_lat", 32'(n), 32'd1);
    chk("t2_done_err", 32'(done_err_o), 32'h0);
    chk("t2_gnts", 32'(g_cnt - g0), 32'd2);
    chk("t2_wready_cnt", 32'(wr_cnt - w0), 32'd2);
    tick();

    // T3: load len 8 with consumer stalled; only FIFO_DEPTH grants allowed
    g0 = g_cnt; p0 = p_cnt;
    rdata_ready_i = 1'b0;
    send_cmd("t3", 1'b0, 32'h3000, 32'd4, 5'd8);
    repeat (10) tick();
    chk("t3_stall_gnts", 32'(g_cnt - g0), 32'd4);
    chk("t3_stall_req", 32'(vdata_req_o), 32'h0);
    chk("t3_head_valid", 32'(rdata_valid_o), 32'h1);
    chk("t3_head_data", rdata_o, 32'hFFFF_CFFF);
    rdata_ready_i = 1'b1;
    wait_done(60, n);
    chk("t3_done", 32'(done_o), 32'h1);
    chk("t3_done_err", 32'(done_err_o), 32'h0);
    chk("t3_gnts", 32'(g_cnt - g0), 32'd8);
    chk("t3_pops", 32'(p_cnt - p0), 32'd8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t3_d%0d", k), p_data[p0+k], ~(32'h3000 + 32'(4*k)));
      chk($sformatf("t3_last%0d", k), 32'(p_last[p0+k]), (k == 7) ? 32'h1 : 32'h0);
    end
    tick();

    // T4: load len 2 with an error on the first response
    p0 = p_cnt;
    err_at = g_cnt;
    send_cmd("t4", 1'b0, 32'h4000, 32'd4, 5'd2);
    wait_done(30, n);
    err_at = -1;
    chk("t4_done", 32'(done_o), 32'h1);
    chk("t4_done_err", 32'(done_err_o), 32'h1);
    chk("t4_pops", 32'(p_cnt - p0), 32'd2);
    chk("t4_d0", p_data[p0],   32'hFFFF_BFFF);
    chk("t4_d1", p_data[p0+1], 32'hFFFF_BFFB);
    chk("t4_last1", 32'(p_last[p0+1]), 32'h1);
    tick();

    // T5: misaligned base / stride and zero length
    r0 = req_cycles;
    send_cmd("t5a", 1'b0, 32'h1002, 32'd4, 5'd3);
    chk("t5a_done", 32'(done_o), 32'h1);
    chk("t5a_err", 32'(done_err_o), 32'h1);
    tick();
    send_cmd("t5b", 1'b0, 32'h1000, 32'd6, 5'd3);
    chk("t5b_done", 32'(done_o), 32'h1);
    chk("t5b_err", 32'(done_err_o), 32'h1);
    tick();
    send_cmd("t5c", 1'b1, 32'h1000, 32'd4, 5'd0);
    chk("t5c_done", 32'(done_o), 32'h1);
    chk("t5c_err", 32'(done_err_o), 32'h0);
    tick();
    chk("t5_no_req", 32'(req_cycles - r0), 32'd0);

    // T6: reset with two requests outstanding, then stale responses
    g0 = g_cnt;
    resp_en = 1'b0;
    send_cmd("t6", 1'b0, 32'h5000, 32'd4, 5'd4);
    tick(); tick();
    vdata_gnt_i = 1'b0;
    chk("t6_gnts", 32'(g_cnt - g0), 32'd2);
    rst_i = 1'b1;
    tick();
    chk("t6_rst_req", 32'(vdata_req_o), 32'h0);
    chk("t6_rst_ready", 32'(cmd_ready_o), 32'h0);
    chk("t6_rst_addr", vdata_addr_o, 32'h0);
    chk("t6_rst_rvalid", 32'(rdata_valid_o), 32'h0);
    chk("t6_rst_rdata", rdata_o, 32'h0);
    chk("t6_rst_be", 32'(vdata_be_o), 32'hF);
    rst_i = 1'b0;
    man_rvalid = 1'b1; man_rdata = 32'hBAD0_BAD0;
    tick(); tick();
    man_rvalid = 1'b0;
    chk("t6_stale_push", 32'(rdata_valid_o), 32'h0);
    chk("t6_idle", 32'(cmd_ready_o), 32'h1);
    vdata_gnt_i = 1'b1; resp_en = 1'b1;
    p0 = p_cnt;
    send_cmd("t6b", 1'b0, 32'h6000, 32'd4, 5'd2);
    wait_done(30, n);
    chk("t6b_done", 32'(done_o), 32'h1);
    chk("t6b_done_err", 32'(done_err_o), 32'h0);
    chk("t6b_pops", 32'(p_cnt - p0), 32'd2);
    chk("t6b_d0", p_data[p0],   32'hFFFF_9FFF);
    chk("t6b_d1", p_data[p0+1], 32'hFFFF_9FFB);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
